// File: rtl/mlab_delay_checker_pkg.sv
// Shared definitions for the MLAB delay-line parity checker and the delay-line side.
package mlab_delay_checker_pkg;

  // Checker FSM: RUN judges captured words, FLUSH blanks the delay-line refill window.
  typedef enum logic {
    StRun   = 1'b0,
    StFlush = 1'b1
  } state_e;

  // Geometry shared with the delay-line implementation.
  localparam int unsigned BLOCK_WIDTH   = 20;
  localparam int unsigned LAB_ADDR_BITS = 5;

  // Flush counter width; holds LATENCY values up to 33.
  localparam int unsigned FLUSH_CNT_BITS = 6;

endpackage

// File: rtl/lane_parity_check.sv
// Single-lane even-parity check: strips the parity MSB and flags a mismatch.
module lane_parity_check
  import mlab_delay_checker_pkg::*;
#(
  parameter int unsigned BITS_PER_WORD = 9
) (
  input  logic [BITS_PER_WORD:0]   lane_i,
  output logic [BITS_PER_WORD-1:0] data_o,
  output logic                     err_o
);

  assign data_o = lane_i[BITS_PER_WORD-1:0];
  assign err_o  = lane_i[BITS_PER_WORD] ^ (^lane_i[BITS_PER_WORD-1:0]);

endmodule

// File: rtl/mlab_delay_checker.sv
// Parity checker on the output of an MLAB delay line. Strips parity, counts errors and
// requests a read-pointer resync, then blanks the LATENCY-cycle refill before judging again.
module mlab_delay_checker
  import mlab_delay_checker_pkg::*;
#(
  parameter int unsigned BITS_PER_WORD = 9,
  parameter int unsigned WORDS         = 46,
  parameter int unsigned LATENCY       = 10,
  parameter int unsigned CNT_BITS      = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              ena,
  input  logic [(BITS_PER_WORD+1)*WORDS-1:0] din,
  input  logic                              clr_count,
  output logic [BITS_PER_WORD*WORDS-1:0]    dout,
  output logic                              dout_valid,
  output logic [WORDS-1:0]                  word_err,
  output logic                              parity_error,
  output logic [CNT_BITS-1:0]               err_count,
  output logic                              resync
);

  localparam int unsigned LaneW = BITS_PER_WORD + 1;
  localparam logic [FLUSH_CNT_BITS-1:0] FlushInit = FLUSH_CNT_BITS'(LATENCY);

  if (LATENCY < 3 || LATENCY > 33) begin : g_latency_check
    $fatal(1, "mlab_delay_checker: LATENCY must be within 3..33");
  end

  logic [BITS_PER_WORD*WORDS-1:0] data_strip;
  logic [WORDS-1:0]               lane_err;
  logic                           any_err;

  for (genvar k = 0; k < WORDS; k++) begin : g_lane
    lane_parity_check #(
      .BITS_PER_WORD(BITS_PER_WORD)
    ) u_lane (
      .lane_i(din[k*LaneW +: LaneW]),
      .data_o(data_strip[k*BITS_PER_WORD +: BITS_PER_WORD]),
      .err_o (lane_err[k])
    );
  end

  assign any_err = |lane_err;

  state_e                    state_q, state_d;
  logic [FLUSH_CNT_BITS-1:0] flush_cnt_q, flush_cnt_d;
  logic                      dout_valid_q, dout_valid_d;
  logic                      resync_q, resync_d;
  logic [BITS_PER_WORD*WORDS-1:0] dout_q;
  logic [WORDS-1:0]          word_err_q;
  logic [CNT_BITS-1:0]       err_count_q, err_count_d;
  logic                      parity_error_q, parity_error_d;
  logic                      count_inc;

  // FSM next state: an error in RUN triggers resync and a LATENCY-long flush.
  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    dout_valid_d = dout_valid_q;
    resync_d     = 1'b0;
    count_inc    = 1'b0;
    if (ena) begin
      unique case (state_q)
        StRun: begin
          if (any_err) begin
            dout_valid_d = 1'b0;
            resync_d     = 1'b1;
            flush_cnt_d  = FlushInit;
            state_d      = StFlush;
            count_inc    = 1'b1;
          end else begin
            dout_valid_d = 1'b1;
          end
        end
        StFlush: begin
          dout_valid_d = 1'b0;
          flush_cnt_d  = flush_cnt_q - FLUSH_CNT_BITS'(1);
          if (flush_cnt_q == FLUSH_CNT_BITS'(1)) begin
            state_d = StRun;
          end
        end
        default: begin
          dout_valid_d = 1'b0;
          flush_cnt_d  = FlushInit;
          state_d      = StFlush;
        end
      endcase
    end
  end

  // Error statistics: clear wins over a same-cycle increment; the count saturates.
  always_comb begin
    err_count_d    = err_count_q;
    parity_error_d = parity_error_q;
    if (clr_count) begin
      err_count_d    = '0;
      parity_error_d = 1'b0;
    end else if (count_inc) begin
      parity_error_d = 1'b1;
      if (err_count_q != {CNT_BITS{1'b1}}) begin
        err_count_d = err_count_q + CNT_BITS'(1);
      end
    end
  end

  // State and status registers; reset starts a full flush to blank the line fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StFlush;
      flush_cnt_q    <= FlushInit;
      dout_valid_q   <= 1'b0;
      resync_q       <= 1'b0;
      err_count_q    <= '0;
      parity_error_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      flush_cnt_q    <= flush_cnt_d;
      dout_valid_q   <= dout_valid_d;
      resync_q       <= resync_d;
      err_count_q    <= err_count_d;
      parity_error_q <= parity_error_d;
    end
  end

  // Data path capture: stripped data and per-lane flags, advanced only on ena.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q     <= '0;
      word_err_q <= '0;
    end else if (ena) begin
      dout_q     <= data_strip;
      word_err_q <= lane_err;
    end
  end

  assign dout         = dout_q;
  assign dout_valid   = dout_valid_q;
  assign word_err     = word_err_q;
  assign parity_error = parity_error_q;
  assign err_count    = err_count_q;
  assign resync       = resync_q;

endmodule
